bp_cce_nonsynth_cfg_multi_loader: RTL and testbench
===================================================

// Module: bp_cce_nonsynth_cfg_multi_loader
// PURPOSE
//  Non-synthesisable testbench loader: copies the CCE microcode boot ROM into the instruction RAM of num_cce_p CCEs over their config links.
//  Splits each instruction into config-link-width beats, optionally broadcasts to all CCEs, optionally reads every beat back and compares.
//  Holds all CCEs frozen until load (and verify) completes; sits between the boot ROM model and the CCE config ports in ME test benches.
// PARAMETERS
//  inst_width_p           48   instruction width in bits
//  inst_ram_addr_width_p  8    instruction RAM index width
//  inst_ram_els_p         256  instructions to load, 1..2**inst_ram_addr_width_p
//  cfg_link_addr_width_p  16   config link address width; config_addr_o is cfg_link_addr_width_p-1 bits
//  cfg_link_data_width_p  32   config link data width
//  num_cce_p              2    number of CCE config channels
//  broadcast_p            0    1: write all channels together; 0: load channels one after another
//  verify_p               1    1: read-back/compare pass after all writes
//  Derived: beats_lp = ceil(inst_width_p/cfg_link_data_width_p); beat_w_lp = max(1,clog2(beats_lp)); last_w_lp = inst_width_p-(beats_lp-1)*cfg_link_data_width_p
// PORTS
//  clk_i            in   1                          clock
//  reset_n_i        in   1                          synchronous reset, active low
//  freeze_o         out  num_cce_p                  per-CCE freeze; 1 until DONE
//  done_o           out  1                          load (and verify) finished
//  error_o          out  1                          sticky: any read-back mismatch
//  mismatch_cnt_o   out  16                         saturating mismatch count
//  boot_rom_addr_o  out  inst_ram_addr_width_p      ROM index; ROM is combinational
//  boot_rom_data_i  in   inst_width_p               ROM instruction, valid same cycle
//  config_addr_o    out  num_cce_p*(cfg_link_addr_width_p-1)  per-channel {inst_idx, beat}
//  config_data_o    out  num_cce_p*cfg_link_data_width_p      per-channel write data
//  config_v_o       out  num_cce_p                  request valid
//  config_w_o       out  num_cce_p                  1 write, 0 read
//  config_ready_i   in   num_cce_p                  channel accepts request
//  config_data_i    in   num_cce_p*cfg_link_data_width_p      read response data
//  config_v_i       in   num_cce_p                  read response valid
//  config_ready_o   out  num_cce_p                  loader accepts response
// BEHAVIOUR
//  Reset (reset_n_i==0 at posedge): state=WRITE, idx=0, beat=0, ch=0, mismatch_cnt=0, error=0. While reset_n_i low all outputs
//   combinationally: freeze_o='1, done_o=0, error_o=0, config_v_o=0, config_w_o=0, config_ready_o=0, addrs/data=0, boot_rom_addr_o=0.
//  Address: config_addr_o = zero-extended {idx, beat[beat_w_lp-1:0]}; boot_rom_addr_o=idx.
//  Beat data: beat b<beats_lp-1 -> boot_rom_data_i[b*cfg_link_data_width_p+:cfg_link_data_width_p]; last beat -> upper last_w_lp bits zero-padded.
//  Counter order: beat inner, idx middle, ch outer (ch fixed at 0 when broadcast_p=1).
//  States:
//   WRITE: v=1,w=1 on active channel(s). Advance when ready: sequential -> config_ready_i[ch]; broadcast -> &config_ready_i
//    (channels not yet ready keep v asserted; channels already accepted drop v for that beat; tracked by per-channel ack mask).
//    Last beat of last idx of last ch -> verify_p ? RD_REQ (counters cleared) : DONE.
//   RD_REQ: v=1,w=0 on active channel(s); on accept -> RD_RESP. Broadcast uses same ack mask rule.
//   RD_RESP: config_ready_o=1 on active channel(s); capture each config_data_i when config_v_i; compare against expected beat
//    (last beat compares low last_w_lp bits only). Per-channel mismatch -> mismatch_cnt+1 (saturate at 16'hFFFF), error=1.
//    All responses received -> advance counters, back to RD_REQ, or DONE after final beat.
//   DONE: terminal. freeze_o=0 on all channels from the cycle after entry, done_o=1; no further link traffic.
//  Latency: one write beat per cycle with ready held high; no bubble between beats or channels.
//  Responses arriving outside RD_RESP are ignored (config_ready_o=0). Read outstanding limited to one per channel.
//  Reset mid-load restarts from idx 0, ch 0, clears error/count; freeze_o reasserts immediately.
//  inst_width_p<=cfg_link_data_width_p -> beats_lp=1, beat field still 1 bit, always 0.
// STRUCTURE
//  bp_cce_pkg: bp_cce_cfg_loader_state_e {e_cfg_write, e_cfg_rd_req, e_cfg_rd_resp, e_cfg_done}.
//  Sub-module bp_cce_cfg_beat_slicer: combinational {inst, beat} -> link data word + compare mask; reused by write and verify paths.
//  Counters and broadcast ack mask live in the top module; no other hierarchy.
// TESTING
//  1 defaults, sequential, ready always 1, verify_p=0 -> 2*256*2=1024 writes, ch0 then ch1, addr 0..511, freeze_o 2'b11->2'b00, done_o=1.
//  2 inst_width_p=48, data 32 -> beat1 data = {16'h0, rom[47:32]}; rom=48'hABCD_1234_5678 gives 32'h1234_5678 then 32'h0000_ABCD.
//  3 broadcast_p=1, ch1 ready stalls 3 cycles per beat -> ch0 v drops after accept, counters advance only when both accepted.
//  4 verify_p=1, memory model corrupts ch1 idx 5 beat 0 -> error_o=1, mismatch_cnt_o=1, done_o still reaches 1.
//  5 random 0/1 ready and response delays 0..4 cycles -> every address written exactly once, order preserved, no lost response.
//  6 assert reset_n_i=0 at idx 100 -> next cycle all v=0, freeze_o='1; after release writes restart at addr 0.

Source files
------------

// File: rtl/bp_cce_pkg.sv
// rtl/bp_cce_pkg.sv - shared types and helpers for the CCE config-link microcode loader
package bp_cce_pkg;

  typedef enum logic [1:0] {
    e_cfg_write,
    e_cfg_rd_req,
    e_cfg_rd_resp,
    e_cfg_done
  } bp_cce_cfg_loader_state_e;

  // Counter field width that never collapses to zero bits when only one value exists.
  function automatic int field_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_cce_cfg_beat_slicer.sv
// rtl/bp_cce_cfg_beat_slicer.sv - picks one config-link beat out of an instruction plus its compare mask
module bp_cce_cfg_beat_slicer
  import bp_cce_pkg::*;
#(
  parameter int inst_width_p = 48,
  parameter int data_width_p = 32,
  parameter int beats_p      = (inst_width_p + data_width_p - 1) / data_width_p,
  parameter int beat_w_p     = field_width(beats_p)
) (
  input  logic [inst_width_p-1:0] inst,
  input  logic [beat_w_p-1:0]     beat,
  output logic [data_width_p-1:0] data,
  output logic [data_width_p-1:0] mask
);

  localparam int padded_w_lp = beats_p * data_width_p;
  localparam int last_w_lp   = inst_width_p - (beats_p - 1) * data_width_p;

  // The final beat carries only the instruction's top bits; the rest is zero padding.
  always_comb begin
    data = data_width_p'(padded_w_lp'(inst) >> (int'(beat) * data_width_p));
    mask = (int'(beat) == beats_p - 1) ? ({data_width_p{1'b1}} >> (data_width_p - last_w_lp))
                                       : {data_width_p{1'b1}};
  end

endmodule

// File: rtl/bp_cce_nonsynth_cfg_multi_loader.sv
// rtl/bp_cce_nonsynth_cfg_multi_loader.sv - boot ROM to CCE instruction RAM loader with broadcast and verify
// Streams each instruction as config-link beats to every CCE, optionally reads back and compares.
module bp_cce_nonsynth_cfg_multi_loader
  import bp_cce_pkg::*;
#(
  parameter int inst_width_p          = 48,
  parameter int inst_ram_addr_width_p = 8,
  parameter int inst_ram_els_p        = 256,
  parameter int cfg_link_addr_width_p = 16,
  parameter int cfg_link_data_width_p = 32,
  parameter int num_cce_p             = 2,
  parameter bit broadcast_p           = 1'b0,
  parameter bit verify_p              = 1'b1
) (
  input  logic                                              clk_i,
  input  logic                                              reset_n_i,
  output logic [num_cce_p-1:0]                              freeze_o,
  output logic                                              done_o,
  output logic                                              error_o,
  output logic [15:0]                                       mismatch_cnt_o,
  output logic [inst_ram_addr_width_p-1:0]                  boot_rom_addr_o,
  input  logic [inst_width_p-1:0]                           boot_rom_data_i,
  output logic [num_cce_p*(cfg_link_addr_width_p-1)-1:0]    config_addr_o,
  output logic [num_cce_p*cfg_link_data_width_p-1:0]        config_data_o,
  output logic [num_cce_p-1:0]                              config_v_o,
  output logic [num_cce_p-1:0]                              config_w_o,
  input  logic [num_cce_p-1:0]                              config_ready_i,
  input  logic [num_cce_p*cfg_link_data_width_p-1:0]        config_data_i,
  input  logic [num_cce_p-1:0]                              config_v_i,
  output logic [num_cce_p-1:0]                              config_ready_o
);

  localparam int beats_lp  = (inst_width_p + cfg_link_data_width_p - 1) / cfg_link_data_width_p;
  localparam int beat_w_lp = field_width(beats_lp);
  localparam int ch_w_lp   = field_width(num_cce_p);
  localparam int addr_w_lp = cfg_link_addr_width_p - 1;
  localparam int dw_lp     = cfg_link_data_width_p;

  bp_cce_cfg_loader_state_e state_q, state_n;
  logic [inst_ram_addr_width_p-1:0] idx_q, idx_n, idx_adv;
  logic [beat_w_lp-1:0] beat_q, beat_n, beat_adv;
  logic [ch_w_lp-1:0]   ch_q, ch_n, ch_adv;
  logic [num_cce_p-1:0] ack_q, ack_n, active, fire, mism;
  logic [15:0]          cnt_q, cnt_n;
  logic                 error_q, error_n;
  logic [16:0]          cnt_sum;
  logic                 last_beat, last_idx, last_ch, final_beat, all_done;
  logic [dw_lp-1:0]     beat_data, beat_mask;
  logic [addr_w_lp-1:0] addr;

  bp_cce_cfg_beat_slicer #(
    .inst_width_p(inst_width_p),
    .data_width_p(dw_lp),
    .beats_p     (beats_lp),
    .beat_w_p    (beat_w_lp)
  ) slicer (
    .inst(boot_rom_data_i),
    .beat(beat_q),
    .data(beat_data),
    .mask(beat_mask)
  );

  assign last_beat  = (beat_q == beat_w_lp'(beats_lp - 1));
  assign last_idx   = (idx_q == inst_ram_addr_width_p'(inst_ram_els_p - 1));
  assign last_ch    = broadcast_p || (ch_q == ch_w_lp'(num_cce_p - 1));
  assign final_beat = last_beat && last_idx && last_ch;
  assign active     = broadcast_p ? '1 : (num_cce_p'(1) << ch_q);
  assign addr       = addr_w_lp'({idx_q, beat_q});

  // Beat is the fastest-moving counter, then instruction index, then channel.
  always_comb begin
    beat_adv = beat_q + 1'b1;
    idx_adv  = idx_q;
    ch_adv   = ch_q;
    if (last_beat) begin
      beat_adv = '0;
      idx_adv  = idx_q + 1'b1;
      if (last_idx) begin
        idx_adv = '0;
        if (!broadcast_p) ch_adv = ch_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_n        = state_q;
    idx_n          = idx_q;
    beat_n         = beat_q;
    ch_n           = ch_q;
    error_n        = error_q;
    config_v_o     = '0;
    config_w_o     = '0;
    config_ready_o = '0;
    fire           = '0;
    mism           = '0;
    cnt_sum        = {1'b0, cnt_q};
    all_done       = 1'b0;
    unique case (state_q)
      e_cfg_write, e_cfg_rd_req: begin
        // ack_q holds channels that already took this beat so they are not asked again.
        config_v_o = active & ~ack_q;
        if (state_q == e_cfg_write) config_w_o = config_v_o;
        fire     = config_v_o & config_ready_i;
        all_done = &(ack_q | fire | ~active);
      end
      e_cfg_rd_resp: begin
        config_ready_o = active & ~ack_q;
        fire           = config_ready_o & config_v_i;
        for (int c = 0; c < num_cce_p; c++) begin
          mism[c] = fire[c] && |((config_data_i[c*dw_lp +: dw_lp] ^ beat_data) & beat_mask);
          cnt_sum = cnt_sum + 17'(mism[c]);
        end
        all_done = &(ack_q | fire | ~active);
      end
      default: ;
    endcase
    cnt_n = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    if (|mism) error_n = 1'b1;
    ack_n = all_done ? '0 : (ack_q | fire);
    if (all_done) begin
      if (state_q == e_cfg_rd_req) begin
        state_n = e_cfg_rd_resp;
      end else begin
        beat_n = beat_adv;
        idx_n  = idx_adv;
        ch_n   = ch_adv;
        if (state_q == e_cfg_rd_resp) state_n = e_cfg_rd_req;
        if (final_beat) begin
          beat_n  = '0;
          idx_n   = '0;
          ch_n    = '0;
          state_n = (state_q == e_cfg_write && verify_p) ? e_cfg_rd_req : e_cfg_done;
        end
      end
    end
    if (!reset_n_i) begin
      config_v_o     = '0;
      config_w_o     = '0;
      config_ready_o = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= e_cfg_write;
      idx_q   <= '0;
      beat_q  <= '0;
      ch_q    <= '0;
      ack_q   <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      beat_q  <= beat_n;
      ch_q    <= ch_n;
      ack_q   <= ack_n;
      cnt_q   <= cnt_n;
      error_q <= error_n;
    end
  end

  assign freeze_o        = (reset_n_i && state_q == e_cfg_done) ? '0 : '1;
  assign done_o          = reset_n_i && (state_q == e_cfg_done);
  assign error_o         = reset_n_i && error_q;
  assign mismatch_cnt_o  = cnt_q;
  assign boot_rom_addr_o = reset_n_i ? idx_q : '0;
  assign config_addr_o   = reset_n_i ? {num_cce_p{addr}} : '0;
  assign config_data_o   = reset_n_i ? {num_cce_p{beat_data}} : '0;

endmodule

// File: tb/tb_bp_cce_nonsynth_cfg_multi_loader.sv
// tb/tb_bp_cce_nonsynth_cfg_multi_loader.sv - randomized bench with a sequential and a broadcast loader
module tb_bp_cce_nonsynth_cfg_multi_loader;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [47:0] rom [256];
  logic [1:0]  freeze [2];
  logic        done [2];
  logic        err [2];
  logic [15:0] mcnt [2];
  logic [7:0]  rom_addr [2];
  logic [47:0] rom_data [2];
  logic [29:0] cfg_addr [2];
  logic [63:0] cfg_wdata [2];
  logic [63:0] rsp_data [2];
  logic [1:0]  req_v [2], req_w [2], req_rdy [2], rsp_v [2], rsp_rdy [2];

  assign rom_data[0] = rom[rom_addr[0]];
  assign rom_data[1] = rom[rom_addr[1]];

  bp_cce_nonsynth_cfg_multi_loader #(.broadcast_p(1'b0), .verify_p(1'b1)) dut_seq (
    .clk_i(clk), .reset_n_i(rstn), .freeze_o(freeze[0]), .done_o(done[0]), .error_o(err[0]),
    .mismatch_cnt_o(mcnt[0]), .boot_rom_addr_o(rom_addr[0]), .boot_rom_data_i(rom_data[0]),
    .config_addr_o(cfg_addr[0]), .config_data_o(cfg_wdata[0]), .config_v_o(req_v[0]),
    .config_w_o(req_w[0]), .config_ready_i(req_rdy[0]), .config_data_i(rsp_data[0]),
    .config_v_i(rsp_v[0]), .config_ready_o(rsp_rdy[0])
  );

  bp_cce_nonsynth_cfg_multi_loader #(.inst_ram_els_p(64), .broadcast_p(1'b1), .verify_p(1'b1)) dut_bc (
    .clk_i(clk), .reset_n_i(rstn), .freeze_o(freeze[1]), .done_o(done[1]), .error_o(err[1]),
    .mismatch_cnt_o(mcnt[1]), .boot_rom_addr_o(rom_addr[1]), .boot_rom_data_i(rom_data[1]),
    .config_addr_o(cfg_addr[1]), .config_data_o(cfg_wdata[1]), .config_v_o(req_v[1]),
    .config_w_o(req_w[1]), .config_ready_i(req_rdy[1]), .config_data_i(rsp_data[1]),
    .config_v_i(rsp_v[1]), .config_ready_o(rsp_rdy[1])
  );

  int checks = 0;
  int bad = 0;
  int cnt [2][2];
  bit pend [2][2];
  int pdly [2][2];
  int paddr [2][2];
  logic [31:0] pdata [2][2];
  logic [31:0] mem [2][2][512];
  bit fin [2];
  int exp_mis [2];
  int first_rd [2];
  logic [31:0] first_wd [2];
  int cyc;
  bit rdy_always;
  int max_dly;

  // Beats per channel per pass: instructions * 2 beats (48-bit instruction, 32-bit link).
  function automatic int n_of(input int k);
    return (k == 0) ? 512 : 128;
  endfunction

  function automatic logic [31:0] beat_word(input logic [47:0] inst, input int beat);
    logic [95:0] wide;
    wide = {48'h0, inst};
    return 32'(wide >> (beat * 32));
  endfunction

  // Global ordering rank of request j on channel c: broadcast runs channels in lockstep,
  // sequential loads ch0 then ch1, then verifies ch0 then ch1.
  function automatic int slot(input int k, input int c, input int j);
    int n;
    n = n_of(k);
    if (k == 1) return j;
    return (j < n) ? c * n + j : 2 * n + c * n + (j - n);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic take_req(input int k, input int c);
    int n, j, o, idx, beat;
    logic [31:0] wd;
    n = n_of(k);
    j = cnt[k][c];
    o = 1 - c;
    if (j >= 2 * n) begin
      chk("extra_request", j, 2 * n - 1);
      return;
    end
    idx  = (j % n) / 2;
    beat = j % 2;
    chk("req_w", req_w[k][c], j < n);
    chk("req_addr", cfg_addr[k][c*15 +: 15], idx * 2 + beat);
    if (cnt[k][o] < 2 * n) chk("req_order", slot(k, o, cnt[k][o]) < slot(k, c, j), 0);
    wd = cfg_wdata[k][c*32 +: 32];
    if (j < n) begin
      chk("req_data", wd, beat_word(rom[idx], beat));
      mem[k][c][idx*2+beat] = wd;
      if (k == 0 && c == 0 && j < 2) first_wd[j] = wd;
    end else begin
      if (first_rd[k] < 0) first_rd[k] = cyc;
      chk("one_outstanding", pend[k][c], 0);
      pend[k][c]  = 1'b1;
      pdly[k][c]  = $urandom_range(0, max_dly);
      paddr[k][c] = idx * 2 + beat;
      pdata[k][c] = mem[k][c][idx*2+beat];
      if (c == 1 && idx == 5 && beat == 0) pdata[k][c] ^= 32'h0000_0001;
      if (c == 0 && idx == 7 && beat == 1) pdata[k][c] ^= 32'h0010_0000;
    end
    cnt[k][c]++;
  endtask

  task automatic take_resp(input int k, input int c);
    int idx, beat;
    logic [31:0] expv, mask;
    pend[k][c] = 1'b0;
    idx  = paddr[k][c] / 2;
    beat = paddr[k][c] % 2;
    expv = beat_word(rom[idx], beat);
    mask = (beat == 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    if (((pdata[k][c] ^ expv) & mask) != 0) exp_mis[k]++;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rstn) begin
        chk("reset_v", req_v[k], 0);
        chk("reset_w", req_w[k], 0);
        chk("reset_rdy", rsp_rdy[k], 0);
        chk("reset_freeze", freeze[k], 2'b11);
        chk("reset_done", done[k], 0);
        chk("reset_err", err[k], 0);
      end else begin
        chk("done", done[k], fin[k]);
        chk("freeze", freeze[k], fin[k] ? 2'b00 : 2'b11);
        chk("mismatch_cnt", mcnt[k], exp_mis[k]);
        chk("error", err[k], exp_mis[k] != 0);
        if (fin[k]) chk("idle_v", req_v[k], 0);
        for (int c = 0; c < 2; c++) begin
          if (rsp_v[k][c] && rsp_rdy[k][c]) take_resp(k, c);
          else if (pend[k][c] && pdly[k][c] > 0) pdly[k][c]--;
          if (req_v[k][c] && req_rdy[k][c]) take_req(k, c);
        end
        if (cnt[k][0] == 2 * n_of(k) && cnt[k][1] == 2 * n_of(k) && !pend[k][0] && !pend[k][1])
          fin[k] = 1'b1;
      end
    end
    if (rstn) cyc++;
  end

  task automatic drive();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 2; c++) begin
        req_rdy[k][c] = rdy_always ? 1'b1 : ($urandom_range(0, 3) < ((c == 1) ? 1 : 2));
        rsp_v[k][c]   = pend[k][c] && pdly[k][c] == 0;
        rsp_data[k][c*32 +: 32] = rsp_v[k][c] ? pdata[k][c] : $urandom;
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cyc  = 0;
    for (int k = 0; k < 2; k++) begin
      fin[k]      = 1'b0;
      exp_mis[k]  = 0;
      first_rd[k] = -1;
      for (int c = 0; c < 2; c++) begin
        cnt[k][c]  = 0;
        pend[k][c] = 1'b0;
        pdly[k][c] = 0;
      end
    end
    drive();
    repeat (3) step();
    rstn = 1'b1;
  endtask

  task automatic load_rom();
    for (int i = 1; i < 256; i++) rom[i] = {16'($urandom), $urandom};
    rom[0] = 48'hABCD_1234_5678;
  endtask

  task automatic run_to_done();
    int n;
    n = 0;
    while (!(fin[0] && fin[1]) && n < 30000) begin
      step();
      n++;
    end
    chk("timeout", fin[0] && fin[1], 1);
    step();
    step();
  endtask

  task automatic end_checks();
    for (int k = 0; k < 2; k++) begin
      chk("final_done", done[k], 1);
      chk("final_freeze", freeze[k], 2'b00);
      chk("final_err", err[k], 1);
      chk("final_mcnt", mcnt[k], 16'd1);
      for (int c = 0; c < 2; c++) chk("final_count", cnt[k][c], 2 * n_of(k));
    end
  endtask

  initial begin
    int n;
    rdy_always = 1'b1;
    max_dly    = 0;
    load_rom();
    do_reset();
    run_to_done();
    end_checks();
    chk("first_read_seq", first_rd[0], 1024);
    chk("first_read_bc", first_rd[1], 128);
    chk("beat0_data", first_wd[0], 32'h1234_5678);
    chk("beat1_data", first_wd[1], 32'h0000_ABCD);

    rdy_always = 1'b0;
    max_dly    = 4;
    load_rom();
    do_reset();
    run_to_done();
    end_checks();

    load_rom();
    do_reset();
    n = 0;
    while (cnt[0][0] < 200 && n < 20000) begin
      step();
      n++;
    end
    chk("reached_idx100", cnt[0][0] >= 200, 1);
    do_reset();
    run_to_done();
    end_checks();

    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule
